// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the arbiter family: FSM state encoding and
// modulo-N index arithmetic.
package rr_arbiter_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Callers guarantee base < n and off <= n, so one subtraction is enough.
   function automatic int idx_add(input int base, input int off, input int n);
      int sum;
      sum = base + off;
      if (sum >= n) sum = sum - n;
      return sum;
   endfunction

endpackage

// File: rtl/rr_mask_select.sv
// Combinational round-robin pick: first set request after ptr, searching
// ptr+1 .. ptr modulo N, via a doubled-vector rotate and lowest-set-bit scan.
module rr_mask_select
   import rr_arbiter_pkg::*;
#(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] win_idx,
   output logic             win_valid
);

   logic [2*N-1:0] doubled;
   logic [N-1:0]   rotated;
   logic [IDX_W:0] shamt;
   int             pos;

   // One extra bit so a shift of exactly N (ptr == N-1) is representable.
   assign shamt   = {1'b0, ptr} + (IDX_W+1)'(1);
   assign doubled = {req, req};
   assign rotated = N'(doubled >> shamt);

   // NOTE: every output gets a default first so no path through the loop
   // leaves a value unassigned and infers a latch.
   always_comb begin
      win_valid = 1'b0;
      pos       = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            win_valid = 1'b1;
            pos       = i;
         end
      end
      win_idx = IDX_W'(idx_add(int'(ptr), pos + 1, N));
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold, done-release and forced rotation
// after MAX_HOLD cycles. Outputs are registered.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N        = 8,
   parameter int IDX_W    = $clog2(N),
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [IDX_W-1:0]  gnt_idx_d;
   logic              gnt_valid_d;
   logic [N-1:0]      gnt_d;
   logic [IDX_W-1:0]  sel_ptr;
   logic [IDX_W-1:0]  win_idx;
   logic              win_valid;
   logic              owner_req;
   logic              release_now;

   // At release the search must already start after the current owner.
   assign sel_ptr = (state_q == ST_GRANT) ? gnt_idx : ptr_q;

   rr_mask_select #(.N(N), .IDX_W(IDX_W)) u_select (
      .req       (req),
      .ptr       (sel_ptr),
      .win_idx   (win_idx),
      .win_valid (win_valid)
   );

   assign owner_req   = |(gnt & req);
   assign release_now = !owner_req || done ||
                        ((MAX_HOLD != 0) && (hold_q == HOLD_LAST));

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      gnt_idx_d   = gnt_idx;
      gnt_valid_d = gnt_valid;
      unique case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d     = ST_GRANT;
               gnt_idx_d   = win_idx;
               gnt_valid_d = 1'b1;
               hold_d      = '0;
            end
         end
         ST_GRANT: begin
            if (!release_now) begin
               if (hold_q != HOLD_SAT) hold_d = hold_q + HOLD_W'(1);
            end else begin
               ptr_d  = gnt_idx;
               hold_d = '0;
               if (win_valid) begin
                  gnt_idx_d   = win_idx;
                  gnt_valid_d = 1'b1;
               end else begin
                  state_d     = ST_IDLE;
                  gnt_idx_d   = '0;
                  gnt_valid_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      gnt_d = gnt_valid_d ? (N'(1) << gnt_idx_d) : '0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= IDX_W'(N - 1);
         hold_q    <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gnt       <= gnt_d;
         gnt_idx   <= gnt_idx_d;
         gnt_valid <= gnt_valid_d;
      end
   end

endmodule
